// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode/func/ALU code constants, control bundle and FSM state shared by the pipeline control slice
package cpu_ctrl_pkg;
  localparam int ALUCTRL_BITS = 4;
  localparam int ALUSRC_BITS = 3;
  localparam logic [5:0] OP_RTYPE = 6'd0, OP_J = 6'd2, OP_JAL = 6'd3, OP_BEQ = 6'd4, OP_BNE = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8, OP_ADDIU = 6'd9, OP_ANDI = 6'd12, OP_ORI = 6'd13, OP_XORI = 6'd14;
  localparam logic [5:0] OP_LW = 6'd35, OP_SW = 6'd43, OP_STOP = 6'd63;
  localparam logic [5:0] FN_SLL = 6'd0, FN_SRL = 6'd2, FN_SRA = 6'd3, FN_SLLV = 6'd4, FN_SRLV = 6'd6, FN_SRAV = 6'd7;
  localparam logic [5:0] FN_JR = 6'd8, FN_ADD = 6'd32, FN_ADDU = 6'd33, FN_SUB = 6'd34, FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND = 6'd36, FN_OR = 6'd37, FN_XOR = 6'd38, FN_NOR = 6'd39, FN_SLT = 6'd42;
  localparam logic [ALUCTRL_BITS-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
  localparam logic [ALUCTRL_BITS-1:0] ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9;
  localparam logic [ALUSRC_BITS-1:0] SRC_RT = 3'd0, SRC_SEXT = 3'd1, SRC_ZEXT = 3'd2, SRC_RS = 3'd3, SRC_SHAMT = 3'd4;
  typedef struct packed {
    logic valid;
    logic regwrite_en;
    logic mem2reg_sel;
    logic memwrite_en;
    logic beq;
    logic bne;
    logic jump;
    logic link;
    logic regdst;
    logic [ALUCTRL_BITS-1:0] aluctrl;
    logic [ALUSRC_BITS-1:0] alusrc;
    logic [4:0] dst;
  } ctrl_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-side instruction fields, pipeline controls and per-stage control bundles
interface pipe_ctrl_if #(parameter int NSTAGE = 3);
  import cpu_ctrl_pkg::*;
  logic id_valid;
  logic [5:0] opcode, func;
  logic [4:0] rs_id, rt_id, rd_id;
  logic stall_ext, flush, hazard_stall, halted;
  ctrl_t [NSTAGE-1:0] ctrl_q;
  modport master(output id_valid, opcode, func, rs_id, rt_id, rd_id, stall_ext, flush, input ctrl_q, hazard_stall, halted);
  modport slave(input id_valid, opcode, func, rs_id, rt_id, rd_id, stall_ext, flush, output ctrl_q, hazard_stall, halted);
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/func decode into a control bundle; unknown encodings become bubbles
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = ALUCTRL_BITS,
  parameter int ALUSRC_W = ALUSRC_BITS
) (
  input  logic       id_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output ctrl_t      dec,
  output logic       is_stop,
  output logic       reads_rt
);
  logic [ALUCTRL_W-1:0] alu;
  logic [ALUSRC_W-1:0] src;
  ctrl_t d;
  always_comb begin
    d = '0;
    alu = '0;
    src = '0;
    reads_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        d.valid = 1'b1;
        d.regwrite_en = 1'b1;
        d.regdst = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: alu = ALUCTRL_W'(ALU_ADD);
          FN_SUB, FN_SUBU: alu = ALUCTRL_W'(ALU_SUB);
          FN_AND: alu = ALUCTRL_W'(ALU_AND);
          FN_OR: alu = ALUCTRL_W'(ALU_OR);
          FN_XOR: alu = ALUCTRL_W'(ALU_XOR);
          FN_NOR: alu = ALUCTRL_W'(ALU_NOR);
          FN_SLT: alu = ALUCTRL_W'(ALU_SLT);
          FN_SLL: begin alu = ALUCTRL_W'(ALU_SLL); src = ALUSRC_W'(SRC_SHAMT); end
          FN_SRL: begin alu = ALUCTRL_W'(ALU_SRL); src = ALUSRC_W'(SRC_SHAMT); end
          FN_SRA: begin alu = ALUCTRL_W'(ALU_SRA); src = ALUSRC_W'(SRC_SHAMT); end
          FN_SLLV: begin alu = ALUCTRL_W'(ALU_SLL); src = ALUSRC_W'(SRC_RS); end
          FN_SRLV: begin alu = ALUCTRL_W'(ALU_SRL); src = ALUSRC_W'(SRC_RS); end
          FN_SRAV: begin alu = ALUCTRL_W'(ALU_SRA); src = ALUSRC_W'(SRC_RS); end
          FN_JR: begin d.regwrite_en = 1'b0; d.regdst = 1'b0; d.jump = 1'b1; end
          default: d = '0;
        endcase
      end
      OP_J: begin d.valid = 1'b1; d.jump = 1'b1; end
      OP_JAL: begin d.valid = 1'b1; d.jump = 1'b1; d.link = 1'b1; d.regwrite_en = 1'b1; end
      OP_BEQ: begin reads_rt = 1'b1; d.valid = 1'b1; d.beq = 1'b1; alu = ALUCTRL_W'(ALU_SUB); end
      OP_BNE: begin reads_rt = 1'b1; d.valid = 1'b1; d.bne = 1'b1; alu = ALUCTRL_W'(ALU_SUB); end
      OP_ADDI, OP_ADDIU: begin d.valid = 1'b1; d.regwrite_en = 1'b1; src = ALUSRC_W'(SRC_SEXT); end
      OP_ANDI: begin d.valid = 1'b1; d.regwrite_en = 1'b1; src = ALUSRC_W'(SRC_ZEXT); alu = ALUCTRL_W'(ALU_AND); end
      OP_ORI: begin d.valid = 1'b1; d.regwrite_en = 1'b1; src = ALUSRC_W'(SRC_ZEXT); alu = ALUCTRL_W'(ALU_OR); end
      OP_XORI: begin d.valid = 1'b1; d.regwrite_en = 1'b1; src = ALUSRC_W'(SRC_ZEXT); alu = ALUCTRL_W'(ALU_XOR); end
      OP_LW: begin d.valid = 1'b1; d.regwrite_en = 1'b1; d.mem2reg_sel = 1'b1; src = ALUSRC_W'(SRC_SEXT); end
      OP_SW: begin reads_rt = 1'b1; d.valid = 1'b1; d.memwrite_en = 1'b1; src = ALUSRC_W'(SRC_SEXT); end
      OP_STOP: d.valid = 1'b1;
      default: d = '0;
    endcase
    d.aluctrl = d.valid ? ALUCTRL_BITS'(alu) : '0;
    d.alusrc = d.valid ? ALUSRC_BITS'(src) : '0;
    d.dst = !d.regwrite_en ? 5'd0 : d.link ? 5'd31 : d.regdst ? rd : rt;
    dec = id_valid ? d : '0;
    is_stop = id_valid && opcode == OP_STOP;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control-bundle stage registers, load-use hazard detection and STOP drain/halt FSM
module pipe_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int ALUCTRL_W = ALUCTRL_BITS,
  parameter int ALUSRC_W = ALUSRC_BITS
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave p
);
  ctrl_t dec;
  ctrl_t [NSTAGE-1:0] stg;
  logic is_stop, reads_rt, haz, adv;
  state_t state;
  logic [2:0] cnt;
  ctrl_decode #(.ALUCTRL_W(ALUCTRL_W), .ALUSRC_W(ALUSRC_W)) u_dec (
    .id_valid(p.id_valid),
    .opcode(p.opcode),
    .func(p.func),
    .rt(p.rt_id),
    .rd(p.rd_id),
    .dec(dec),
    .is_stop(is_stop),
    .reads_rt(reads_rt)
  );
  always_comb begin
    haz = state == RUN && dec.valid && stg[0].valid && stg[0].mem2reg_sel && stg[0].dst != 5'd0 &&
          (stg[0].dst == p.rs_id || (reads_rt && stg[0].dst == p.rt_id));
    adv = !p.stall_ext && state != HALT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg <= '0;
      state <= RUN;
      cnt <= '0;
    end else if (adv) begin
      for (int i = NSTAGE - 1; i > 0; i--) stg[i] <= stg[i-1];
      stg[0] <= (state != RUN || p.flush || haz) ? '0 : dec;
      if (state == DRAIN) begin
        cnt <= cnt == 3'(NSTAGE - 1) ? 3'd0 : cnt + 3'd1;
        if (cnt == 3'(NSTAGE - 1)) state <= HALT;
      end else if (is_stop && !p.flush && !haz) state <= DRAIN;
    end
  end
  assign p.ctrl_q = stg;
  assign p.hazard_stall = haz;
  assign p.halted = state == HALT;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench; a queue-based pipeline model predicts every stage, hazard_stall and halted
module tb_pipe_ctrl;
  import cpu_ctrl_pkg::*;
  localparam int NS = 3;
  typedef struct {
    bit haz;
    bit halt;
    ctrl_t [NS-1:0] st;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  pipe_ctrl_if #(.NSTAGE(NS)) pif();
  pipe_ctrl #(.NSTAGE(NS)) dut (.clk(clk), .rst_n(rst_n), .p(pif));
  exp_t sb[$];
  ctrl_t pipe[$];
  int fn_alu[64], fn_src[64];
  int cmp = 0, mism = 0, left = 0;
  bit draining = 0, halt_m = 0, known = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic ctrl_t ref_dec(input bit v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt, input logic [4:0] rd);
    ctrl_t c = '0;
    if (!v) return c;
    case (op)
      6'd0: if (fn == 6'd8) begin c.valid = 1; c.jump = 1; end
            else if (fn_alu[fn] >= 0) begin
              c.valid = 1; c.regwrite_en = 1; c.regdst = 1;
              c.aluctrl = 4'(fn_alu[fn]); c.alusrc = 3'(fn_src[fn]); c.dst = rd;
            end
      6'd2: begin c.valid = 1; c.jump = 1; end
      6'd3: begin c.valid = 1; c.jump = 1; c.link = 1; c.regwrite_en = 1; c.dst = 5'd31; end
      6'd4: begin c.valid = 1; c.beq = 1; c.aluctrl = 4'd1; end
      6'd5: begin c.valid = 1; c.bne = 1; c.aluctrl = 4'd1; end
      6'd8, 6'd9: begin c.valid = 1; c.regwrite_en = 1; c.alusrc = 3'd1; c.dst = rt; end
      6'd12, 6'd13, 6'd14: begin c.valid = 1; c.regwrite_en = 1; c.alusrc = 3'd2; c.aluctrl = 4'(op - 6'd10); c.dst = rt; end
      6'd35: begin c.valid = 1; c.regwrite_en = 1; c.mem2reg_sel = 1; c.alusrc = 3'd1; c.dst = rt; end
      6'd43: begin c.valid = 1; c.memwrite_en = 1; c.alusrc = 3'd1; end
      6'd63: c.valid = 1;
      default: ;
    endcase
    return c;
  endfunction
  task automatic step(input bit v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input bit st, input bit fl, input bit rn);
    exp_t e;
    ctrl_t d, s0;
    bit haz, rdt;
    @(posedge clk);
    #1;
    pif.id_valid = v; pif.opcode = op; pif.func = fn; pif.rs_id = rs; pif.rt_id = rt; pif.rd_id = rd;
    pif.stall_ext = st; pif.flush = fl; rst_n = rn;
    d = ref_dec(v, op, fn, rt, rd);
    s0 = pipe.size() > 0 ? pipe[0] : ctrl_t'('0);
    rdt = op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43;
    haz = known && !draining && !halt_m && d.valid && s0.valid && s0.mem2reg_sel && s0.dst != 5'd0 &&
          (s0.dst == rs || (rdt && s0.dst == rt));
    if (known) begin
      e.haz = haz;
      e.halt = halt_m;
      for (int k = 0; k < NS; k++) e.st[k] = pipe[k];
      sb.push_back(e);
    end
    if (!rn) begin
      pipe = {};
      repeat (NS) pipe.push_back('0);
      draining = 0; halt_m = 0; known = 1;
    end else if (known && !st && !halt_m) begin
      void'(pipe.pop_back());
      pipe.push_front((draining || fl || haz) ? ctrl_t'('0) : d);
      if (draining) begin
        left--;
        if (left == 0) begin draining = 0; halt_m = 1; end
      end else if (d.valid && op == 6'd63 && !fl && !haz) begin
        draining = 1; left = NS;
      end
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("hazard_stall", 32'(pif.hazard_stall), 32'(e.haz));
      check("halted", 32'(pif.halted), 32'(e.halt));
      for (int k = 0; k < NS; k++) check($sformatf("stage%0d", k), 32'(pif.ctrl_q[k]), 32'(e.st[k]));
    end
  end
  initial begin
    logic [5:0] ops[17] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 12, 13, 14, 35, 35, 43, 17, 1};
    logic [5:0] fns[18] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 0, 2, 3, 4, 6, 7, 8, 1, 50};
    logic [5:0] op, fn;
    foreach (fn_alu[i]) begin fn_alu[i] = -1; fn_src[i] = 0; end
    fn_alu[32] = 0; fn_alu[33] = 0; fn_alu[34] = 1; fn_alu[35] = 1; fn_alu[36] = 2; fn_alu[37] = 3;
    fn_alu[38] = 4; fn_alu[39] = 5; fn_alu[42] = 6;
    fn_alu[0] = 7; fn_src[0] = 4; fn_alu[4] = 7; fn_src[4] = 3;
    fn_alu[2] = 8; fn_src[2] = 4; fn_alu[6] = 8; fn_src[6] = 3;
    fn_alu[3] = 9; fn_src[3] = 4; fn_alu[7] = 9; fn_src[7] = 3;
    pif.id_valid = 0; pif.opcode = 0; pif.func = 0; pif.rs_id = 0; pif.rt_id = 0; pif.rd_id = 0;
    pif.stall_ext = 0; pif.flush = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32, 1, 2, 3, 0, 0, 1);
    repeat (NS) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 35, 0, 1, 8, 0, 0, 0, 1);
    step(1, 0, 32, 8, 2, 4, 0, 0, 1);
    step(1, 0, 32, 8, 2, 4, 0, 0, 1);
    step(1, 35, 0, 1, 9, 0, 0, 0, 1);
    step(1, 43, 0, 2, 9, 0, 0, 0, 1);
    step(1, 43, 0, 2, 9, 0, 0, 0, 1);
    step(1, 5, 0, 1, 2, 0, 0, 1, 1);
    step(1, 13, 0, 1, 2, 0, 0, 0, 1);
    step(1, 5, 0, 1, 2, 0, 1, 0, 1);
    step(1, 5, 0, 1, 2, 0, 1, 1, 1);
    step(1, 5, 0, 1, 2, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0, 0, 0, 1);
    step(1, 63, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 32, 1, 2, 3, 0, 0, 1);
    step(1, 35, 0, 1, 5, 0, 1, 0, 1);
    repeat (NS + 3) step(1, 0, 32, 1, 2, 3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 63, 0, 0, 0, 0, 0, 0, 1);
    step(1, 8, 0, 0, 7, 0, 0, 0, 1);
    step(1, 17, 0, 0, 7, 0, 0, 0, 0);
    step(1, 17, 0, 1, 2, 3, 0, 0, 1);
    step(0, 35, 0, 1, 6, 0, 0, 0, 1);
    step(1, 0, 0, 1, 2, 3, 0, 0, 1);
    for (int n = 0; n < 2000; n++) begin
      op = ($urandom_range(0, 99) < 3) ? 6'd63 : ops[$urandom_range(0, 16)];
      fn = fns[$urandom_range(0, 17)];
      step($urandom_range(0, 9) != 0, op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) >= 3);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
